// File: rtl/t09_apple_placer.sv
// t09_apple_placer
// Picks a free playfield cell and a color for a new apple. A random candidate is
// taken from the free-running rng word and range-checked against the grid. An
// in-range candidate is sent out as a one-cycle occupancy query. The block then
// waits for the occupancy answer. A free cell commits the apple. An out-of-range
// or occupied cell costs one try. After MAX_TRIES failed tries the block gives up.
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous, active-low
//   rng[15:0]            random word: x=[3:0], y=[7:4], color=[10:8]
//   place_req            start a placement (accepted only when idle)
//   occ_valid, occupied  occupancy answer for the current query
//   query_x/y, query_valid  candidate under query, one-cycle strobe
//   apple_x/y, apple_color  committed apple
//   busy, done, fail     in-progress level, success pulse, give-up pulse
module t09_apple_placer #(
    parameter int GRID_W    = 12,
    parameter int GRID_H    = 8,
    parameter int MAX_TRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rng,
    input  logic        place_req,
    input  logic        occ_valid,
    input  logic        occupied,
    output logic [3:0]  query_x,
    output logic [3:0]  query_y,
    output logic        query_valid,
    output logic [3:0]  apple_x,
    output logic [3:0]  apple_y,
    output logic [2:0]  apple_color,
    output logic        busy,
    output logic        done,
    output logic        fail
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] TRY_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRY_LAST = CNT_W'(MAX_TRIES);
    localparam logic [4:0] GRID_W_C = 5'(GRID_W);
    localparam logic [4:0] GRID_H_C = 5'(GRID_H);

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_QUERY, S_WAIT, S_FAIL
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tries, tries_nxt;
    logic [2:0]       cand_color;

    logic [3:0] qx_nxt, qy_nxt, ax_nxt, ay_nxt;
    logic [2:0] col_nxt, acol_nxt;
    logic       qv_nxt, done_nxt, fail_nxt, busy_nxt;
    logic       in_range, reject;

    // Seven colors are available. The raw value 7 folds onto the last color.
    function automatic logic [2:0] map_color(input logic [2:0] c);
        return (c == 3'd7) ? 3'd6 : c;
    endfunction

    assign in_range = ({1'b0, rng[3:0]} < GRID_W_C) && ({1'b0, rng[7:4]} < GRID_H_C);

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            tries       <= '0;
            cand_color  <= '0;
            query_x     <= '0;
            query_y     <= '0;
            query_valid <= 1'b0;
            apple_x     <= '0;
            apple_y     <= '0;
            apple_color <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_nxt;
            tries       <= tries_nxt;
            cand_color  <= col_nxt;
            query_x     <= qx_nxt;
            query_y     <= qy_nxt;
            query_valid <= qv_nxt;
            apple_x     <= ax_nxt;
            apple_y     <= ay_nxt;
            apple_color <= acol_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            fail        <= fail_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        tries_nxt = tries;
        reject    = 1'b0;
        case (state)
            S_IDLE: begin
                if (place_req) begin
                    state_nxt = S_SAMPLE;
                    tries_nxt = '0;
                end
            end
            S_SAMPLE: begin
                if (in_range) state_nxt = S_QUERY;
                else          reject    = 1'b1;
            end
            S_QUERY: state_nxt = S_WAIT;
            S_WAIT: begin
                if (occ_valid) begin
                    if (occupied) reject    = 1'b1;
                    else          state_nxt = S_IDLE;
                end
            end
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A rejection either spends one more try or, on the last one, gives up.
        if (reject) begin
            if (tries + TRY_ONE == TRY_LAST) begin
                state_nxt = S_FAIL;
            end else begin
                state_nxt = S_SAMPLE;
                tries_nxt = tries + TRY_ONE;
            end
        end
    end

    // Output next values. These are registered together with the state.
    always_comb begin
        qx_nxt   = query_x;
        qy_nxt   = query_y;
        col_nxt  = cand_color;
        ax_nxt   = apple_x;
        ay_nxt   = apple_y;
        acol_nxt = apple_color;
        if (state == S_SAMPLE) begin
            qx_nxt  = rng[3:0];
            qy_nxt  = rng[7:4];
            col_nxt = map_color(rng[10:8]);
        end
        qv_nxt   = (state == S_SAMPLE) && (state_nxt == S_QUERY);
        done_nxt = (state == S_WAIT) && occ_valid && !occupied;
        if (done_nxt) begin
            ax_nxt   = query_x;
            ay_nxt   = query_y;
            acol_nxt = cand_color;
        end
        fail_nxt = (state_nxt == S_FAIL);
        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_t09_apple_placer.sv
module tb_t09_apple_placer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rng;
    logic        place_req, occ_valid, occupied;
    logic [3:0]  query_x, query_y, apple_x, apple_y;
    logic        query_valid, busy, done, fail;
    logic [2:0]  apple_color;

    always #5 clk = ~clk;

    t09_apple_placer #(.GRID_W(12), .GRID_H(8), .MAX_TRIES(4)) dut (
        .clk(clk), .reset(reset), .rng(rng), .place_req(place_req),
        .occ_valid(occ_valid), .occupied(occupied),
        .query_x(query_x), .query_y(query_y), .query_valid(query_valid),
        .apple_x(apple_x), .apple_y(apple_y), .apple_color(apple_color),
        .busy(busy), .done(done), .fail(fail)
    );

    localparam int K_Q = 0, K_D = 1, K_F = 2;
    typedef struct {
        int       kind;
        int       x;
        int       y;
        int       c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int x, input int y, input int c);
        exp_t e;
        e.kind = kind; e.x = x; e.y = y; e.c = c;
        exp_q.push_back(e);
    endtask

    // Monitor: each query, done or fail event the DUT presents is matched against the scoreboard.
    task automatic pop_cmp(input int kind, input int x, input int y, input int c);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: kind %0d at (%0d,%0d) c=%0d, expected none", kind, x, y, c);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_x", x, e.x);
            chk("event_y", y, e.y);
            if (kind != K_Q) chk("event_color", c, e.c);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (done && fail) chk("done_and_fail", 1, 0);
            if (query_valid) pop_cmp(K_Q, int'(query_x), int'(query_y), 0);
            if (done)        pop_cmp(K_D, int'(apple_x), int'(apple_y), int'(apple_color));
            if (fail)        pop_cmp(K_F, int'(apple_x), int'(apple_y), int'(apple_color));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the query, then answers it in WAIT.
    task automatic respond(input bit occ);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (query_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) begin
            chk("query_timeout", 0, 1);
        end else begin
            tick();
            occ_valid = 1'b1;
            occupied  = occ;
            tick();
            occ_valid = 1'b0;
            occupied  = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_qx"}, int'(query_x), 0);
        chk({name, "_qy"}, int'(query_y), 0);
        chk({name, "_qv"}, int'(query_valid), 0);
        chk({name, "_ax"}, int'(apple_x), 0);
        chk({name, "_ay"}, int'(apple_y), 0);
        chk({name, "_ac"}, int'(apple_color), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_fail"}, int'(fail), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        reset = 1'b0; rng = 16'h0; place_req = 1'b0; occ_valid = 1'b0; occupied = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();
        mon_en = 1'b1;

        // Best case: rng 0253 gives (3,5) color 2; occ_valid held high, including in IDLE and QUERY.
        rng = 16'h0253; occ_valid = 1'b1; occupied = 1'b0; place_req = 1'b1;
        push(K_Q, 3, 5, 0); push(K_D, 3, 5, 2);
        tick();                       // edge N
        place_req = 1'b0;
        chk("lat_busy_n", int'(busy), 1);
        tick();                       // N+1
        chk("lat_qv_n1", int'(query_valid), 1);
        chk("lat_done_n1", int'(done), 0);
        tick();                       // N+2
        chk("lat_done_n2", int'(done), 0);
        tick();                       // N+3
        chk("lat_done_n3", int'(done), 1);
        occ_valid = 1'b0;
        tick();
        chk("lat_done_n4", int'(done), 0);
        chk("lat_busy_n4", int'(busy), 0);

        // Out-of-range x first, then 0021 gives (1,2) color 0.
        rng = 16'h07FF; place_req = 1'b1;
        push(K_Q, 1, 2, 0); push(K_D, 1, 2, 0);
        tick();
        place_req = 1'b0;
        tick();                       // rejection of 07FF
        rng = 16'h0021;
        respond(1'b0);
        chk("r31_ax", int'(apple_x), 1);
        chk("r31_ay", int'(apple_y), 2);
        chk("r31_ac", int'(apple_color), 0);

        // Occupied twice at (3,2), then 0444 is free.
        rng = 16'h0723; place_req = 1'b1;
        push(K_Q, 3, 2, 0); push(K_Q, 3, 2, 0); push(K_Q, 4, 4, 0); push(K_D, 4, 4, 4);
        tick();
        place_req = 1'b0;
        respond(1'b1);
        respond(1'b1);
        rng = 16'h0444;
        respond(1'b0);
        chk("r32_ac", int'(apple_color), 4);

        // Four rejections with MAX_TRIES=4 end in a fail pulse; apple stays (4,4,4).
        rng = 16'h00FF; place_req = 1'b1;
        push(K_F, 4, 4, 4);
        tick();
        place_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fail) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("r33_fail_seen", int'(got), 1);
        chk("r33_busy_in_fail", int'(busy), 1);
        tick();
        chk("r33_busy_after", int'(busy), 0);
        chk("r33_fail_after", int'(fail), 0);
        chk("r33_ax", int'(apple_x), 4);

        // Reset while waiting for the occupancy answer.
        rng = 16'h0253; place_req = 1'b1;
        push(K_Q, 3, 5, 0);
        tick();
        place_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (query_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("r34_query_seen", int'(got), 1);
        tick();                       // now in WAIT
        reset = 1'b0; place_req = 1'b1; occ_valid = 1'b1; occupied = 1'b0;
        tick();
        chk_all_zero("r34_rst");
        tick();
        chk("r34_busy_hold", int'(busy), 0);
        chk("r34_done_hold", int'(done), 0);
        reset = 1'b1; occ_valid = 1'b0; rng = 16'h0021;
        push(K_Q, 1, 2, 0); push(K_D, 1, 2, 0);
        tick();                       // first edge out of reset accepts the request
        place_req = 1'b0;
        chk("r34_accept", int'(busy), 1);
        respond(1'b0);
        chk("r34_ax", int'(apple_x), 1);

        // Stray occ_valid in IDLE, then place_req held high throughout one operation.
        occ_valid = 1'b1; occupied = 1'b0;
        tick(); tick();
        chk("r35_idle_busy", int'(busy), 0);
        occ_valid = 1'b0;
        rng = 16'h0165; place_req = 1'b1;
        push(K_Q, 5, 6, 0); push(K_D, 5, 6, 1);
        respond(1'b0);
        place_req = 1'b0;
        chk("r35_done", int'(done), 1);
        tick(); tick();
        chk("r35_busy_end", int'(busy), 0);
        chk("r35_ac", int'(apple_color), 1);

        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t09_apple_placer.md
T09_APPLE_PLACER -- requirements
Module: t09_apple_placer

Interface
REQ-001 SHALL have parameter GRID_W, default 12, playfield columns (1..16).
REQ-002 SHALL have parameter GRID_H, default 8, playfield rows (1..16).
REQ-003 SHALL have parameter MAX_TRIES, default 16, candidate rejections before giving up (1..31).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port rng  input  16  free-running random value from t09_rainbowRand.
REQ-007 SHALL have port place_req  input  1  request a new apple placement.
REQ-008 SHALL have port occ_valid  input  1  occupancy response valid.
REQ-009 SHALL have port occupied  input  1  queried cell is occupied; meaningful only with occ_valid.
REQ-010 SHALL have ports query_x / query_y  output  4 / 4  candidate cell under query.
REQ-011 SHALL have port query_valid  output  1  occupancy query strobe.
REQ-012 SHALL have ports apple_x / apple_y  output  4 / 4  committed apple position.
REQ-013 SHALL have port apple_color  output  3  committed apple color index (0..6).
REQ-014 SHALL have ports busy, done, fail  output  1 each  in-progress level, success pulse, give-up pulse.

Function
REQ-015 SHALL implement FSM states IDLE, SAMPLE, QUERY, WAIT, FAIL; all outputs registered.
REQ-016 IDLE: place_req=1 -> SAMPLE, try counter cleared; place_req while not IDLE SHALL be ignored (no queueing).
REQ-017 SAMPLE: candidate x=rng[3:0], y=rng[7:4], color=rng[10:8], with 3'd7 mapped to 3'd6; all captured on the same edge.
REQ-018 SAMPLE: x>=GRID_W or y>=GRID_H -> rejection; otherwise -> QUERY with candidate held in query_x/query_y.
REQ-019 QUERY: query_valid SHALL be 1 for exactly this one cycle -> WAIT; query_x/query_y SHALL stay stable until next SAMPLE.
REQ-020 WAIT: hold until occ_valid=1; occupied=1 -> rejection; occupied=0 -> commit.
REQ-021 Commit: apple_x, apple_y, apple_color load the candidate, and done=1 for exactly one cycle, on the same edge; -> IDLE.
REQ-022 Rejection: if try count+1 == MAX_TRIES -> FAIL, else try count increments -> SAMPLE, which samples the rng value of the next cycle.
REQ-023 FAIL: fail=1 for exactly one cycle; apple_* unchanged -> IDLE.
REQ-024 busy SHALL be 1 in SAMPLE, QUERY, WAIT, FAIL; 0 in IDLE; done and fail SHALL never both be 1.
REQ-025 occ_valid outside WAIT SHALL be ignored.
REQ-026 Best-case latency: place_req sampled at edge N -> done high during cycle after edge N+3.
REQ-027 Try counter width SHALL hold MAX_TRIES without overflow; no wrap.

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE, clear the try counter, and set every output to 0, including mid-operation (no done/fail issued).
REQ-029 While reset=0, place_req and occ_valid SHALL have no effect; the first request is accepted on the first edge with reset=1.

Verification
REQ-030 rng=16'h0253, place_req 1 cycle, occ_valid=1/occupied=0 in WAIT -> query (3,5); done pulse; apple_x=3, apple_y=5, apple_color=2.
REQ-031 rng=16'h07FF (x=15, out of range) then 16'h0021 -> one rejection without query; commit (1,2), color 0.
REQ-032 rng=16'h0723 with occupied=1 twice, then 16'h0444 free -> two queries of (3,2), then commit (4,4), color 4.
REQ-033 MAX_TRIES=4, rng held at 16'h00FF -> 4 rejections; fail pulse; apple_* unchanged; busy drops next cycle.
REQ-034 reset=0 asserted in WAIT -> all outputs 0 next cycle; no done/fail; fresh place_req after reset completes normally.
REQ-035 place_req held high during an operation plus stray occ_valid in IDLE -> exactly one done per IDLE-accepted request; no spurious state change.
